// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage RV pipeline. It resolves the
//   hazards that the EX-stage forwarding unit cannot cover:
//     - load-use: inserts one bubble into ID/EX and holds PC and IF/ID
//     - taken branch/jump resolved in EX: flushes IF/ID and ID/EX
//     - multi-cycle dmem access: freezes the whole pipe, faulting after
//       MEM_TIMEOUT consecutive wait cycles
//   It also keeps saturating perf counters for stall cycles and flushes.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1, id_rs2             source registers of the instruction in IF/ID
//   id_uses_rs1, id_uses_rs2   the IF/ID instruction really reads rs1/rs2
//   ex_mem_read, ex_rd         the ID/EX instruction is a load / its dest reg
//   ex_redirect                branch taken or jump resolved in EX
//   mem_req, mem_ready         dmem access in EX/MEM / access completes now
//   fault_clr                  leave FAULT
//   cnt_clr                    synchronous clear of both perf counters
//   pc_we, if_id_we, id_ex_we, ex_mem_we   pipeline register write enables
//   if_id_flush, id_ex_bubble, mem_wb_bubble  NOP insertion controls
//   mem_fault                  high while in FAULT
//   stall_cycles, flush_count  saturating perf counters
module pipeline_stall_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  fault_clr,
  input  logic                  cnt_clr,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_we,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_we,
  output logic                  mem_wb_bubble,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            lduse;
  logic            freeze;
  logic            flush;
  logic            ld_stall;

  // Load-use hazard: x0 never carries a dependency.
  always_comb begin
    lduse = ex_mem_read && (ex_rd != '0) &&
            ((id_uses_rs1 && (ex_rd == id_rs1)) ||
             (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state and pipeline controls. The hazard class is decided first by
  // priority (FAULT > mem wait > redirect > load-use); the enables are then
  // derived from it and forced low while reset is asserted.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    freeze        = 1'b0;
    flush         = 1'b0;
    ld_stall      = 1'b0;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_fault     = (state == FAULT);

    if (state == FAULT) begin
      freeze = 1'b1;
      if (fault_clr) begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    end else if (mem_req && !mem_ready) begin
      freeze    = 1'b1;
      wait_nxt  = wait_cnt + 1'b1;
      state_nxt = (wait_cnt == WAIT_LAST) ? FAULT : MEM_WAIT;
    end else begin
      // Completion (or mem_req dropping) releases the pipe this very cycle,
      // so a redirect held in EX during the freeze is taken now.
      state_nxt = RUN;
      wait_nxt  = '0;
      if (ex_redirect) begin
        flush = 1'b1;
      end else if (lduse) begin
        ld_stall = 1'b1;
      end
    end

    if (rst_n) begin
      if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else if (flush) begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_we    = 1'b1;
      end else if (ld_stall) begin
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_we    = 1'b1;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        id_ex_we  = 1'b1;
        ex_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((freeze || ld_stall) && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush && !(&flush_count)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic          mem_req, mem_ready, fault_clr, cnt_clr;
  logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
  logic          ex_mem_we, mem_wb_bubble, mem_fault;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_stall_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .fault_clr(fault_clr), .cnt_clr(cnt_clr),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] O_NORM   = 7'b1101010;
  localparam logic [6:0] O_LDUSE  = 7'b0001110;
  localparam logic [6:0] O_FLUSH  = 7'b1111110;
  localparam logic [6:0] O_FREEZE = 7'b0000001;
  localparam logic [6:0] O_ZERO   = 7'b0000000;

  logic [6:0] outs;
  assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mrd;
    logic [4:0] rd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
    logic [6:0] exp;
    logic       ds;
    logic       df;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; fault_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_lduse();
    id_rs1 = 5'd5; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5;
  endtask

  // Inputs are already driven (just after posedge); check comb outputs at
  // negedge, then advance one edge and check the counters.
  task automatic cycle(input string name, input logic [6:0] exp, input logic ds, input logic df);
    @(negedge clk);
    chk({name, "_outs"}, 32'(outs), 32'(exp));
    @(posedge clk); #1;
    if (ds) exp_stall = sat_inc(exp_stall);
    if (df) exp_flush = sat_inc(exp_flush);
    chk({name, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
    chk({name, "_flush"}, 32'(flush_count), 32'(exp_flush));
  endtask

  vec_t tbl[10];

  initial begin
    //          rs1   rs2   u1 u2 mrd rd   rdr mrq mrdy exp      ds df
    tbl[0] = '{5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 0, O_NORM,  0, 0}; // plain ALU
    tbl[1] = '{5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 0, 0, O_LDUSE, 1, 0}; // ld x5 ; add x6,x5,x7
    tbl[2] = '{5'd0, 5'd7, 1, 1, 1, 5'd0, 0, 0, 0, O_NORM,  0, 0}; // ld x0 never hazards
    tbl[3] = '{5'd5, 5'd7, 0, 1, 1, 5'd5, 0, 0, 0, O_NORM,  0, 0}; // rs1 not read
    tbl[4] = '{5'd1, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0, O_LDUSE, 1, 0}; // rs2 match
    tbl[5] = '{5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 0, 0, O_FLUSH, 0, 1}; // redirect beats lduse
    tbl[6] = '{5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 0, O_FLUSH, 0, 1}; // redirect alone
    tbl[7] = '{5'd5, 5'd7, 1, 1, 0, 5'd5, 0, 0, 0, O_NORM,  0, 0}; // not a load
    tbl[8] = '{5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 1, 1, O_LDUSE, 1, 0}; // dmem ready same cycle
    tbl[9] = '{5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 1, 1, O_FLUSH, 0, 1}; // dmem ready + redirect

    idle();
    rst_n = 1'b0;
    set_lduse(); ex_redirect = 1'b1;
    #2;
    chk("reset_outs", 32'(outs), 32'(O_ZERO));
    chk("reset_fault", 32'(mem_fault), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    idle();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mrd; ex_rd = tbl[i].rd; ex_redirect = tbl[i].redir;
      mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
      cycle($sformatf("vec%0d", i), tbl[i].exp, tbl[i].ds, tbl[i].df);
    end

    // dmem wait 3 cycles with a redirect held in EX, released on the 4th
    idle();
    set_lduse(); ex_redirect = 1'b1; mem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("wait_nofault", 32'(mem_fault), 32'd0);
      cycle($sformatf("wait%0d", k), O_FREEZE, 1, 0);
    end
    mem_ready = 1'b1;
    cycle("release", O_FLUSH, 0, 1);
    idle();
    cycle("after_release", O_NORM, 0, 0);

    // mem_req dropping during MEM_WAIT counts as completion
    mem_req = 1'b1;
    cycle("drop_wait", O_FREEZE, 1, 0);
    mem_req = 1'b0;
    cycle("drop_done", O_NORM, 0, 0);

    // timeout: FAULT exactly after the 16th wait edge (stall counter saturates)
    mem_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("to_nofault%0d", k), 32'(mem_fault), 32'd0);
      cycle($sformatf("to%0d", k), O_FREEZE, 1, 0);
    end
    chk("fault_set", 32'(mem_fault), 32'd1);
    idle(); ex_redirect = 1'b1;
    cycle("fault_hold", O_FREEZE, 1, 0);
    fault_clr = 1'b1;
    chk("fault_still", 32'(mem_fault), 32'd1);
    cycle("fault_clr", O_FREEZE, 1, 0);
    chk("fault_left", 32'(mem_fault), 32'd0);
    chk("stall_sat", 32'(stall_cycles), 32'hF);
    idle();
    cycle("post_fault", O_NORM, 0, 0);

    // saturated counter holds; cnt_clr wins over increment
    set_lduse();
    cycle("sat_hold", O_LDUSE, 1, 0);
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_outs", 32'(outs), 32'(O_LDUSE));
    @(posedge clk); #1;
    exp_stall = '0; exp_flush = '0;
    chk("clr_stall", 32'(stall_cycles), 32'd0);
    chk("clr_flush", 32'(flush_count), 32'd0);

    // async reset in the middle of FAULT
    idle();
    mem_req = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("fault_again", 32'(mem_fault), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_outs", 32'(outs), 32'(O_ZERO));
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    #1;
    rst_n = 1'b1;
    idle();
    exp_stall = '0; exp_flush = '0;
    cycle("rst_run", O_NORM, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
